atp_txn_ctrl: RTL and testbench
===============================

ATP_TXN_CTRL -- requirements
Module: atp_txn_ctrl

Interface
REQ-001 Parameter AMT_W, 16, width of amount, balance and debit values.
REQ-002 Parameter TIMEOUT_CYC, 1000, cycles a waiting state may persist without an event (>=2).
REQ-003 Parameter MAX_RETRY, 3, retries allowed after a failed payment attempt (1..15).
REQ-004 One clock, clk; reset rst is asynchronous and active-low.
REQ-005 Ports: clk in 1 clock; rst in 1 async active-low reset; qr_valid in 1 QR scanned; amount in AMT_W bill amount; balance in AMT_W account balance; confirm in 1 user confirms displayed data; use_bal in 1 pay from balance first.
REQ-006 Ports: cancel in 1 user abort; method_valid in 1 method chosen; method in 2 (0 card, 1 UPI, 2 cash, 3 DD/cheque); pay_done in 1 gateway result strobe; pay_ok in 1 gateway approved; prn_ack in 1 printer accepted receipt.
REQ-007 Ports: state out 4 current state code; busy out 1 state!=IDLE; ext_due out AMT_W amount owed to external method; method_q out 2 latched method; retry_cnt out 4 retries used.
REQ-008 Ports: txn_ok out 1 success pulse; txn_fail out 1 failure pulse; fail_code out 2 failure cause; debit_valid out 1 debit strobe; bal_debit out AMT_W; ext_debit out AMT_W; receipt_req out 1.

Function
REQ-009 States/codes: IDLE 0, DISPLAY 1, CHOOSE 2, BAL_DEBIT 3, METHOD 4, PAY_WAIT 6, FAIL 9, SUCCESS 10, RECEIPT 11; all other codes -> IDLE next cycle.
REQ-010 IDLE: qr_valid=1 -> DISPLAY; amount and balance latched into amt_q, bal_q same edge; retry_cnt cleared.
REQ-011 DISPLAY: confirm -> CHOOSE.
REQ-012 CHOOSE (1 cycle): use_bal=1 and bal_q>=amt_q -> BAL_DEBIT; use_bal=1 and bal_q<amt_q -> METHOD, ext_due=amt_q-bal_q, bal portion=bal_q; use_bal=0 -> METHOD, ext_due=amt_q, bal portion=0.
REQ-013 BAL_DEBIT (1 cycle): bal portion=amt_q, ext_due=0 -> SUCCESS.
REQ-014 METHOD: method_valid=1 -> PAY_WAIT, method latched into method_q.
REQ-015 PAY_WAIT: pay_done=1 and pay_ok=1 -> SUCCESS; pay_done=1 and pay_ok=0 -> FAIL; timeout -> FAIL.
REQ-016 FAIL (1 cycle): retry_cnt<MAX_RETRY -> METHOD, retry_cnt+1; else -> IDLE with txn_fail=1, fail_code=3.
REQ-017 SUCCESS (1 cycle): txn_ok=1, debit_valid=1, bal_debit=bal portion, ext_debit=ext_due; bal_debit+ext_debit equals amt_q exactly; -> RECEIPT.
REQ-018 RECEIPT: receipt_req=1 while in state; prn_ack=1 or timeout -> IDLE; no failure reported.
REQ-019 cancel=1 in DISPLAY, CHOOSE, METHOD, PAY_WAIT -> IDLE, txn_fail=1, fail_code=1, no debit.
REQ-020 Timeout in DISPLAY or METHOD -> IDLE, txn_fail=1, fail_code=2.
REQ-021 Timeout counter clears on every state change, counts in DISPLAY, METHOD, PAY_WAIT, RECEIPT; timeout fires when state held TIMEOUT_CYC cycles with no event.
REQ-022 Priority per cycle: cancel > confirm/method_valid/pay_done/prn_ack > timeout.
REQ-023 txn_ok, txn_fail, debit_valid are single-cycle registered pulses, asserted the cycle after the causing transition; fail_code holds until next txn_fail; inputs ignored in states not listing them.

Reset
REQ-024 rst=0 forces IDLE immediately, asynchronously, from any state including mid-payment.
REQ-025 Reset values: state 0, busy 0, all pulses 0, fail_code 0, retry_cnt 0, method_q 0, ext_due/bal_debit/ext_debit 0, receipt_req 0, timeout counter 0.
REQ-026 Transaction interrupted by reset produces no debit_valid and no txn_fail.

Configuration
REQ-027 Macro ATP_RECEIPT_EN defined: RECEIPT state present per REQ-018.
REQ-028 ATP_RECEIPT_EN undefined: SUCCESS -> IDLE directly, receipt_req tied 0, prn_ack ignored, code 11 unreachable.

Verification
REQ-029 amount=100, balance=250, use_bal=1, confirm -> BAL_DEBIT, SUCCESS; debit_valid with bal_debit=100, ext_debit=0; txn_ok one cycle; RECEIPT until prn_ack -> IDLE.
REQ-030 amount=300, balance=120, use_bal=1 -> ext_due=180; method=1, pay_done=pay_ok=1 -> bal_debit=120, ext_debit=180.
REQ-031 MAX_RETRY=3, four declines (pay_ok=0) -> retry_cnt=3, txn_fail with fail_code=3, IDLE, no debit_valid.
REQ-032 TIMEOUT_CYC=8, enter DISPLAY, no inputs -> IDLE exactly 8 cycles after entry, fail_code=2.
REQ-033 PAY_WAIT with cancel=1 and pay_done=pay_ok=1 same cycle -> IDLE, fail_code=1, no debit_valid.
REQ-034 rst=0 pulse mid PAY_WAIT -> state 0 before next clk edge, all outputs 0; rebuild without ATP_RECEIPT_EN -> SUCCESS followed by IDLE, receipt_req never 1.

Source files
------------

// File: rtl/atp_txn_ctrl.sv
// atp_txn_ctrl -- payment transaction controller for a QR-initiated bill
// payment terminal.
//
// Flow: IDLE -> DISPLAY (QR scanned, bill/balance latched) -> CHOOSE
// (split bill between account balance and an external method) ->
// BAL_DEBIT (balance covers everything) or METHOD/PAY_WAIT (external
// gateway, with retries on decline/timeout) -> SUCCESS (debit strobe)
// -> RECEIPT (optional) -> IDLE.
//
// Parameters:
//   AMT_W       width of amount / balance / debit values
//   TIMEOUT_CYC cycles a waiting state may persist without an event (>=2)
//   MAX_RETRY   retries allowed after a failed payment attempt (1..15)
//
// Optional feature macro: ATP_RECEIPT_EN
//   defined   : RECEIPT state (code 11) waits for prn_ack or timeout
//   undefined : SUCCESS returns straight to IDLE, receipt_req is 0,
//               prn_ack is ignored
//
// Ports:
//   clk, rst (async, active-low)
//   in : qr_valid, amount, balance, confirm, use_bal, cancel,
//        method_valid, method, pay_done, pay_ok, prn_ack
//   out: state, busy, ext_due, method_q, retry_cnt, txn_ok, txn_fail,
//        fail_code, debit_valid, bal_debit, ext_debit, receipt_req
//   All outputs are driven directly from registers.
module atp_txn_ctrl #(
  parameter int AMT_W       = 16,
  parameter int TIMEOUT_CYC = 1000,
  parameter int MAX_RETRY   = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             qr_valid,
  input  logic [AMT_W-1:0] amount,
  input  logic [AMT_W-1:0] balance,
  input  logic             confirm,
  input  logic             use_bal,
  input  logic             cancel,
  input  logic             method_valid,
  input  logic [1:0]       method,
  input  logic             pay_done,
  input  logic             pay_ok,
  input  logic             prn_ack,
  output logic [3:0]       state,
  output logic             busy,
  output logic [AMT_W-1:0] ext_due,
  output logic [1:0]       method_q,
  output logic [3:0]       retry_cnt,
  output logic             txn_ok,
  output logic             txn_fail,
  output logic [1:0]       fail_code,
  output logic             debit_valid,
  output logic [AMT_W-1:0] bal_debit,
  output logic [AMT_W-1:0] ext_debit,
  output logic             receipt_req
);

  localparam logic [3:0] ST_IDLE      = 4'd0;
  localparam logic [3:0] ST_DISPLAY   = 4'd1;
  localparam logic [3:0] ST_CHOOSE    = 4'd2;
  localparam logic [3:0] ST_BAL_DEBIT = 4'd3;
  localparam logic [3:0] ST_METHOD    = 4'd4;
  localparam logic [3:0] ST_PAY_WAIT  = 4'd6;
  localparam logic [3:0] ST_FAIL      = 4'd9;
  localparam logic [3:0] ST_SUCCESS   = 4'd10;
  localparam logic [3:0] ST_RECEIPT   = 4'd11;

  localparam logic [1:0] FC_CANCEL  = 2'd1;
  localparam logic [1:0] FC_TIMEOUT = 2'd2;
  localparam logic [1:0] FC_RETRY   = 2'd3;

  localparam int             TW       = $clog2(TIMEOUT_CYC);
  localparam logic [TW-1:0]  TMO_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [3:0]     RETRY_MAX = 4'(MAX_RETRY);

  logic [3:0]       r_state;
  logic             r_busy;
  logic [AMT_W-1:0] r_amt_q;
  logic [AMT_W-1:0] r_bal_q;
  logic [AMT_W-1:0] r_ext_due;
  logic [AMT_W-1:0] r_bal_part;
  logic [1:0]       r_method_q;
  logic [3:0]       r_retry;
  logic [TW-1:0]    r_tmo_cnt;
  logic             r_txn_ok;
  logic             r_txn_fail;
  logic [1:0]       r_fail_code;
  logic             r_debit_valid;
  logic [AMT_W-1:0] r_bal_debit;
  logic [AMT_W-1:0] r_ext_debit;
  logic             r_receipt_req;

  logic [3:0]       w_state_nx;
  logic [AMT_W-1:0] w_amt_nx;
  logic [AMT_W-1:0] w_bal_nx;
  logic [AMT_W-1:0] w_ext_due_nx;
  logic [AMT_W-1:0] w_bal_part_nx;
  logic [1:0]       w_method_nx;
  logic [3:0]       w_retry_nx;
  logic             w_fail_set;
  logic [1:0]       w_fail_code_nx;
  logic             w_count;
  logic             w_tmo;
  logic             w_enter_succ;

`ifdef ATP_RECEIPT_EN
  localparam logic RCPT_EN = 1'b1;
`else
  localparam logic RCPT_EN = 1'b0;
  // prn_ack has no consumer when the receipt stage is built out.
  logic w_unused_prn_ack;
  assign w_unused_prn_ack = prn_ack;
`endif

  // Waiting states run the timeout counter; transient states do not.
  assign w_count = (r_state == ST_DISPLAY) || (r_state == ST_METHOD) ||
                   (r_state == ST_PAY_WAIT) ||
                   (RCPT_EN && (r_state == ST_RECEIPT));
  assign w_tmo   = w_count && (r_tmo_cnt == TMO_LAST);

  // Debit strobe fires on every entry into SUCCESS, from either path.
  assign w_enter_succ = (w_state_nx == ST_SUCCESS) && (r_state != ST_SUCCESS);

  // Next-state and datapath-next logic; priority cancel > event > timeout.
  always_comb begin
    w_state_nx     = r_state;
    w_amt_nx       = r_amt_q;
    w_bal_nx       = r_bal_q;
    w_ext_due_nx   = r_ext_due;
    w_bal_part_nx  = r_bal_part;
    w_method_nx    = r_method_q;
    w_retry_nx     = r_retry;
    w_fail_set     = 1'b0;
    w_fail_code_nx = r_fail_code;
    case (r_state)
      ST_IDLE: begin
        if (qr_valid) begin
          w_state_nx    = ST_DISPLAY;
          w_amt_nx      = amount;
          w_bal_nx      = balance;
          w_retry_nx    = 4'd0;
          w_ext_due_nx  = {AMT_W{1'b0}};
          w_bal_part_nx = {AMT_W{1'b0}};
        end else begin
          w_state_nx = ST_IDLE;
        end
      end
      ST_DISPLAY: begin
        if (cancel) begin
          w_state_nx     = ST_IDLE;
          w_fail_set     = 1'b1;
          w_fail_code_nx = FC_CANCEL;
        end else if (confirm) begin
          w_state_nx = ST_CHOOSE;
        end else if (w_tmo) begin
          w_state_nx     = ST_IDLE;
          w_fail_set     = 1'b1;
          w_fail_code_nx = FC_TIMEOUT;
        end else begin
          w_state_nx = ST_DISPLAY;
        end
      end
      ST_CHOOSE: begin
        if (cancel) begin
          w_state_nx     = ST_IDLE;
          w_fail_set     = 1'b1;
          w_fail_code_nx = FC_CANCEL;
        end else if (use_bal && (r_bal_q >= r_amt_q)) begin
          w_state_nx = ST_BAL_DEBIT;
        end else if (use_bal) begin
          // Balance is drained completely; gateway covers the remainder.
          w_state_nx    = ST_METHOD;
          w_ext_due_nx  = r_amt_q - r_bal_q;
          w_bal_part_nx = r_bal_q;
        end else begin
          w_state_nx    = ST_METHOD;
          w_ext_due_nx  = r_amt_q;
          w_bal_part_nx = {AMT_W{1'b0}};
        end
      end
      ST_BAL_DEBIT: begin
        w_state_nx    = ST_SUCCESS;
        w_bal_part_nx = r_amt_q;
        w_ext_due_nx  = {AMT_W{1'b0}};
      end
      ST_METHOD: begin
        if (cancel) begin
          w_state_nx     = ST_IDLE;
          w_fail_set     = 1'b1;
          w_fail_code_nx = FC_CANCEL;
        end else if (method_valid) begin
          w_state_nx  = ST_PAY_WAIT;
          w_method_nx = method;
        end else if (w_tmo) begin
          w_state_nx     = ST_IDLE;
          w_fail_set     = 1'b1;
          w_fail_code_nx = FC_TIMEOUT;
        end else begin
          w_state_nx = ST_METHOD;
        end
      end
      ST_PAY_WAIT: begin
        if (cancel) begin
          w_state_nx     = ST_IDLE;
          w_fail_set     = 1'b1;
          w_fail_code_nx = FC_CANCEL;
        end else if (pay_done) begin
          w_state_nx = pay_ok ? ST_SUCCESS : ST_FAIL;
        end else if (w_tmo) begin
          // A silent gateway counts as a failed attempt, not an abort.
          w_state_nx = ST_FAIL;
        end else begin
          w_state_nx = ST_PAY_WAIT;
        end
      end
      ST_FAIL: begin
        if (r_retry < RETRY_MAX) begin
          w_state_nx = ST_METHOD;
          w_retry_nx = r_retry + 4'd1;
        end else begin
          w_state_nx     = ST_IDLE;
          w_fail_set     = 1'b1;
          w_fail_code_nx = FC_RETRY;
        end
      end
      ST_SUCCESS: begin
        w_state_nx = RCPT_EN ? ST_RECEIPT : ST_IDLE;
      end
`ifdef ATP_RECEIPT_EN
      ST_RECEIPT: begin
        if (prn_ack || w_tmo) begin
          w_state_nx = ST_IDLE;
        end else begin
          w_state_nx = ST_RECEIPT;
        end
      end
`endif
      default: begin
        w_state_nx = ST_IDLE;
      end
    endcase
  end

  // State, latched transaction data and timeout counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_busy     <= 1'b0;
      r_amt_q    <= {AMT_W{1'b0}};
      r_bal_q    <= {AMT_W{1'b0}};
      r_ext_due  <= {AMT_W{1'b0}};
      r_bal_part <= {AMT_W{1'b0}};
      r_method_q <= 2'd0;
      r_retry    <= 4'd0;
      r_tmo_cnt  <= {TW{1'b0}};
    end else begin
      r_state    <= w_state_nx;
      r_busy     <= (w_state_nx != ST_IDLE);
      r_amt_q    <= w_amt_nx;
      r_bal_q    <= w_bal_nx;
      r_ext_due  <= w_ext_due_nx;
      r_bal_part <= w_bal_part_nx;
      r_method_q <= w_method_nx;
      r_retry    <= w_retry_nx;
      if (w_state_nx != r_state) begin
        r_tmo_cnt <= {TW{1'b0}};
      end else if (w_count) begin
        r_tmo_cnt <= r_tmo_cnt + {{(TW-1){1'b0}}, 1'b1};
      end else begin
        r_tmo_cnt <= {TW{1'b0}};
      end
    end
  end

  // Result pulses, failure cause and debit values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_txn_ok      <= 1'b0;
      r_txn_fail    <= 1'b0;
      r_fail_code   <= 2'd0;
      r_debit_valid <= 1'b0;
      r_bal_debit   <= {AMT_W{1'b0}};
      r_ext_debit   <= {AMT_W{1'b0}};
      r_receipt_req <= 1'b0;
    end else begin
      r_txn_ok      <= w_enter_succ;
      r_debit_valid <= w_enter_succ;
      r_txn_fail    <= w_fail_set;
      r_fail_code   <= w_fail_code_nx;
      r_receipt_req <= RCPT_EN && (w_state_nx == ST_RECEIPT);
      if (w_enter_succ) begin
        r_bal_debit <= w_bal_part_nx;
        r_ext_debit <= w_ext_due_nx;
      end else begin
        r_bal_debit <= r_bal_debit;
        r_ext_debit <= r_ext_debit;
      end
    end
  end

  assign state       = r_state;
  assign busy        = r_busy;
  assign ext_due     = r_ext_due;
  assign method_q    = r_method_q;
  assign retry_cnt   = r_retry;
  assign txn_ok      = r_txn_ok;
  assign txn_fail    = r_txn_fail;
  assign fail_code   = r_fail_code;
  assign debit_valid = r_debit_valid;
  assign bal_debit   = r_bal_debit;
  assign ext_debit   = r_ext_debit;
  assign receipt_req = r_receipt_req;

endmodule

// File: tb/tb_atp_txn_ctrl.sv
// Self-checking bench for atp_txn_ctrl: table of directed vectors for the
// main payment flows, plus hand-written sequences for retries, timeouts,
// cancel priority and asynchronous reset.
module tb_atp_txn_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        qr_valid, confirm, use_bal, cancel, method_valid;
  logic        pay_done, pay_ok, prn_ack;
  logic [15:0] amount, balance;
  logic [1:0]  method;
  logic [3:0]  state;
  logic        busy;
  logic [15:0] ext_due;
  logic [1:0]  method_q;
  logic [3:0]  retry_cnt;
  logic        txn_ok, txn_fail;
  logic [1:0]  fail_code;
  logic        debit_valid;
  logic [15:0] bal_debit, ext_debit;
  logic        receipt_req;

  int n_checks = 0;
  int n_err    = 0;
  logic rr_seen = 1'b0;

`ifdef ATP_RECEIPT_EN
  localparam logic RCPT = 1'b1;
`else
  localparam logic RCPT = 1'b0;
`endif
  localparam logic [3:0] ST_AS = RCPT ? 4'd11 : 4'd0;

  atp_txn_ctrl #(.AMT_W(16), .TIMEOUT_CYC(8), .MAX_RETRY(3)) dut (
    .clk(clk), .rst(rst), .qr_valid(qr_valid), .amount(amount),
    .balance(balance), .confirm(confirm), .use_bal(use_bal),
    .cancel(cancel), .method_valid(method_valid), .method(method),
    .pay_done(pay_done), .pay_ok(pay_ok), .prn_ack(prn_ack),
    .state(state), .busy(busy), .ext_due(ext_due), .method_q(method_q),
    .retry_cnt(retry_cnt), .txn_ok(txn_ok), .txn_fail(txn_fail),
    .fail_code(fail_code), .debit_valid(debit_valid),
    .bal_debit(bal_debit), .ext_debit(ext_debit), .receipt_req(receipt_req)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (receipt_req === 1'b1) rr_seen <= 1'b1;
  end

  typedef struct {
    logic qr; logic [15:0] amt; logic [15:0] bal;
    logic conf, ub, can, mv; logic [1:0] meth; logic pd, pok, ack;
    logic [3:0] st; logic [15:0] due; logic ok, fail; logic [1:0] fc;
    logic dv; logic [15:0] bd, ed; logic [1:0] mq; logic [3:0] rc;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(
    input logic qr, input logic [15:0] amt, input logic [15:0] bal,
    input logic conf, input logic ub, input logic can, input logic mv,
    input logic [1:0] meth, input logic pd, input logic pok, input logic ack,
    input logic [3:0] st, input logic [15:0] due, input logic ok,
    input logic fail, input logic [1:0] fc, input logic dv,
    input logic [15:0] bd, input logic [15:0] ed, input logic [1:0] mq,
    input logic [3:0] rc);
    vec_t v;
    v.qr = qr; v.amt = amt; v.bal = bal; v.conf = conf; v.ub = ub;
    v.can = can; v.mv = mv; v.meth = meth; v.pd = pd; v.pok = pok;
    v.ack = ack; v.st = st; v.due = due; v.ok = ok; v.fail = fail;
    v.fc = fc; v.dv = dv; v.bd = bd; v.ed = ed; v.mq = mq; v.rc = rc;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic clr();
    qr_valid = 1'b0; confirm = 1'b0; use_bal = 1'b0; cancel = 1'b0;
    method_valid = 1'b0; method = 2'd0; pay_done = 1'b0; pay_ok = 1'b0;
    prn_ack = 1'b0; amount = 16'd0; balance = 16'd0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // IDLE -> DISPLAY -> CHOOSE -> METHOD without using the balance.
  task automatic to_method(input logic [15:0] a, input logic [15:0] b);
    clr(); qr_valid = 1'b1; amount = a; balance = b; cyc();
    clr(); confirm = 1'b1; cyc();
    clr(); cyc();
  endtask

  initial begin
    clr();
    rst = 1'b0;
    #2;
    chk("rst_state", state, 4'd0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_pulses", {txn_ok, txn_fail, debit_valid, receipt_req}, 4'd0);
    chk("rst_data", {ext_due, bal_debit, ext_debit}, 48'd0);
    chk("rst_misc", {fail_code, method_q, retry_cnt}, 8'd0);
    @(negedge clk);
    rst = 1'b1;

    //          qr amt    bal   cf ub cn mv mt pd ok ak | st   due  ok fl fc dv bd    ed    mq rc
    // Balance covers the bill.
    vq.push_back(mk(1, 16'd100, 16'd250, 0,0,0,0,2'd0,0,0,0, 4'd1, 16'd0, 0,0,2'd0,0,16'd0,16'd0,2'd0,4'd0));
    vq.push_back(mk(0, 16'd0, 16'd0,     1,1,0,0,2'd0,0,0,0, 4'd2, 16'd0, 0,0,2'd0,0,16'd0,16'd0,2'd0,4'd0));
    vq.push_back(mk(0, 16'd0, 16'd0,     0,1,0,0,2'd0,0,0,0, 4'd3, 16'd0, 0,0,2'd0,0,16'd0,16'd0,2'd0,4'd0));
    vq.push_back(mk(0, 16'd0, 16'd0,     0,0,0,0,2'd0,0,0,0, 4'd10,16'd0, 1,0,2'd0,1,16'd100,16'd0,2'd0,4'd0));
    vq.push_back(mk(0, 16'd0, 16'd0,     0,0,0,0,2'd0,0,0,0, ST_AS,16'd0, 0,0,2'd0,0,16'd0,16'd0,2'd0,4'd0));
    vq.push_back(mk(0, 16'd0, 16'd0,     0,0,0,0,2'd0,0,0,1, 4'd0, 16'd0, 0,0,2'd0,0,16'd0,16'd0,2'd0,4'd0));
    // Split: 120 from balance, 180 via UPI.
    vq.push_back(mk(1, 16'd300, 16'd120, 0,0,0,0,2'd0,0,0,0, 4'd1, 16'd0, 0,0,2'd0,0,16'd0,16'd0,2'd0,4'd0));
    vq.push_back(mk(0, 16'd0, 16'd0,     1,1,0,0,2'd0,0,0,0, 4'd2, 16'd0, 0,0,2'd0,0,16'd0,16'd0,2'd0,4'd0));
    vq.push_back(mk(0, 16'd0, 16'd0,     0,1,0,0,2'd0,0,0,0, 4'd4, 16'd180,0,0,2'd0,0,16'd0,16'd0,2'd0,4'd0));
    vq.push_back(mk(0, 16'd0, 16'd0,     0,0,0,1,2'd1,0,0,0, 4'd6, 16'd180,0,0,2'd0,0,16'd0,16'd0,2'd1,4'd0));
    vq.push_back(mk(0, 16'd0, 16'd0,     0,0,0,0,2'd0,1,1,0, 4'd10,16'd180,1,0,2'd0,1,16'd120,16'd180,2'd1,4'd0));
    vq.push_back(mk(0, 16'd0, 16'd0,     0,0,0,0,2'd0,0,0,0, ST_AS,16'd180,0,0,2'd0,0,16'd0,16'd0,2'd1,4'd0));
    vq.push_back(mk(0, 16'd0, 16'd0,     0,0,0,0,2'd0,0,0,1, 4'd0, 16'd180,0,0,2'd0,0,16'd0,16'd0,2'd1,4'd0));
    // Balance not used: whole bill via cash.
    vq.push_back(mk(1, 16'd50, 16'd999,  0,0,0,0,2'd0,0,0,0, 4'd1, 16'd0, 0,0,2'd0,0,16'd0,16'd0,2'd1,4'd0));
    vq.push_back(mk(0, 16'd0, 16'd0,     1,0,0,0,2'd0,0,0,0, 4'd2, 16'd0, 0,0,2'd0,0,16'd0,16'd0,2'd1,4'd0));
    vq.push_back(mk(0, 16'd0, 16'd0,     0,0,0,0,2'd0,0,0,0, 4'd4, 16'd50, 0,0,2'd0,0,16'd0,16'd0,2'd1,4'd0));
    vq.push_back(mk(0, 16'd0, 16'd0,     0,0,0,1,2'd2,0,0,0, 4'd6, 16'd50, 0,0,2'd0,0,16'd0,16'd0,2'd2,4'd0));
    vq.push_back(mk(0, 16'd0, 16'd0,     0,0,0,0,2'd0,1,1,0, 4'd10,16'd50, 1,0,2'd0,1,16'd0,16'd50,2'd2,4'd0));
    vq.push_back(mk(0, 16'd0, 16'd0,     0,0,0,0,2'd0,0,0,0, ST_AS,16'd50, 0,0,2'd0,0,16'd0,16'd0,2'd2,4'd0));
    vq.push_back(mk(0, 16'd0, 16'd0,     0,0,0,0,2'd0,0,0,1, 4'd0, 16'd50, 0,0,2'd0,0,16'd0,16'd0,2'd2,4'd0));
    // Zero balance, cancel in METHOD; then stray inputs in IDLE are ignored.
    vq.push_back(mk(1, 16'd10, 16'd0,    0,0,0,0,2'd0,0,0,0, 4'd1, 16'd0, 0,0,2'd0,0,16'd0,16'd0,2'd2,4'd0));
    vq.push_back(mk(0, 16'd0, 16'd0,     1,1,0,0,2'd0,0,0,0, 4'd2, 16'd0, 0,0,2'd0,0,16'd0,16'd0,2'd2,4'd0));
    vq.push_back(mk(0, 16'd0, 16'd0,     0,1,0,0,2'd0,0,0,0, 4'd4, 16'd10, 0,0,2'd0,0,16'd0,16'd0,2'd2,4'd0));
    vq.push_back(mk(0, 16'd0, 16'd0,     0,0,1,0,2'd0,0,0,0, 4'd0, 16'd10, 0,1,2'd1,0,16'd0,16'd0,2'd2,4'd0));
    vq.push_back(mk(0, 16'd0, 16'd0,     1,1,0,1,2'd3,1,1,1, 4'd0, 16'd10, 0,0,2'd1,0,16'd0,16'd0,2'd2,4'd0));

    for (int i = 0; i < vq.size(); i++) begin
      qr_valid = vq[i].qr; amount = vq[i].amt; balance = vq[i].bal;
      confirm = vq[i].conf; use_bal = vq[i].ub; cancel = vq[i].can;
      method_valid = vq[i].mv; method = vq[i].meth; pay_done = vq[i].pd;
      pay_ok = vq[i].pok; prn_ack = vq[i].ack;
      cyc();
      chk($sformatf("v%0d_state", i), state, vq[i].st);
      chk($sformatf("v%0d_busy", i), busy, (vq[i].st != 4'd0));
      chk($sformatf("v%0d_ext_due", i), ext_due, vq[i].due);
      chk($sformatf("v%0d_pulses", i), {txn_ok, txn_fail, debit_valid},
          {vq[i].ok, vq[i].fail, vq[i].dv});
      chk($sformatf("v%0d_fail_code", i), fail_code, vq[i].fc);
      chk($sformatf("v%0d_method_q", i), method_q, vq[i].mq);
      chk($sformatf("v%0d_retry", i), retry_cnt, vq[i].rc);
      chk($sformatf("v%0d_receipt", i), receipt_req, (vq[i].st == 4'd11));
      if (vq[i].dv) begin
        chk($sformatf("v%0d_bal_debit", i), bal_debit, vq[i].bd);
        chk($sformatf("v%0d_ext_debit", i), ext_debit, vq[i].ed);
      end
    end

    // Four declines exhaust the retries.
    to_method(16'd300, 16'd120);
    for (int k = 0; k < 4; k++) begin
      clr(); method_valid = 1'b1; cyc();
      chk($sformatf("dec%0d_paywait", k), state, 4'd6);
      clr(); pay_done = 1'b1; pay_ok = 1'b0; cyc();
      chk($sformatf("dec%0d_fail_state", k), state, 4'd9);
      chk($sformatf("dec%0d_no_debit", k), debit_valid, 1'b0);
      clr(); cyc();
      if (k < 3) begin
        chk($sformatf("dec%0d_back_method", k), state, 4'd4);
        chk($sformatf("dec%0d_retry", k), retry_cnt, 4'(k + 1));
        chk($sformatf("dec%0d_no_fail", k), txn_fail, 1'b0);
      end else begin
        chk("dec_final_state", state, 4'd0);
        chk("dec_final_retry", retry_cnt, 4'd3);
        chk("dec_final_fail", {txn_fail, fail_code, debit_valid}, {1'b1, 2'd3, 1'b0});
      end
    end
    clr(); cyc();
    chk("dec_fail_pulse_one_cycle", txn_fail, 1'b0);

    // DISPLAY timeout: IDLE exactly 8 cycles after entry.
    clr(); qr_valid = 1'b1; amount = 16'd5; balance = 16'd5; cyc();
    clr();
    for (int j = 1; j < 8; j++) begin
      cyc();
      chk($sformatf("tmo_disp_hold%0d", j), state, 4'd1);
    end
    cyc();
    chk("tmo_disp_idle", state, 4'd0);
    chk("tmo_disp_fail", {txn_fail, fail_code}, {1'b1, 2'd2});

    // PAY_WAIT timeout is a failed attempt; then cancel from METHOD.
    to_method(16'd40, 16'd0);
    clr(); method_valid = 1'b1; cyc();
    clr();
    for (int j = 1; j < 8; j++) begin
      cyc();
      chk($sformatf("tmo_pw_hold%0d", j), state, 4'd6);
    end
    cyc();
    chk("tmo_pw_fail_state", state, 4'd9);
    cyc();
    chk("tmo_pw_retry", {state, retry_cnt}, {4'd4, 4'd1});
    cancel = 1'b1; cyc();
    chk("cancel_method", {state, txn_fail, fail_code}, {4'd0, 1'b1, 2'd1});

    // Cancel wins over a simultaneous approval.
    to_method(16'd70, 16'd0);
    clr(); method_valid = 1'b1; cyc();
    clr(); cancel = 1'b1; pay_done = 1'b1; pay_ok = 1'b1; cyc();
    chk("cancel_prio_state", state, 4'd0);
    chk("cancel_prio_flags", {txn_fail, fail_code, txn_ok, debit_valid},
        {1'b1, 2'd1, 1'b0, 1'b0});
    clr(); cyc();
    chk("cancel_prio_no_late_debit", debit_valid, 1'b0);

    // Asynchronous reset in the middle of PAY_WAIT.
    to_method(16'd90, 16'd30);
    clr(); method = 2'd3; method_valid = 1'b1; cyc();
    clr();
    chk("rstmid_pre_state", state, 4'd6);
    #2;
    rst = 1'b0;
    #1;
    chk("rstmid_state", state, 4'd0);
    chk("rstmid_outputs", {busy, txn_ok, txn_fail, debit_valid, receipt_req,
                           fail_code, method_q, retry_cnt}, 14'd0);
    chk("rstmid_amounts", {ext_due, bal_debit, ext_debit}, 48'd0);
    @(negedge clk);
    rst = 1'b1;
    cyc();
    chk("rstmid_after", {state, txn_fail, debit_valid}, 6'd0);

    chk("receipt_seen", rr_seen, RCPT);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
